// File: rtl/afe_att_spi_shifter_if.sv
// afe_att_spi_shifter_if: CSR handshake and AFE SPI pins of one attenuator shifter.
// The master side is software/CSR logic; the slave side is the shifter itself.
interface afe_att_spi_shifter_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] lastValue;
   logic             SPI_CLK;
   logic             SPI_SDI;
   logic             SPI_LE;
   modport master (output start, data, input busy, done, lastValue, SPI_CLK, SPI_SDI, SPI_LE);
   modport slave  (input start, data, output busy, done, lastValue, SPI_CLK, SPI_SDI, SPI_LE);
endinterface

// File: rtl/afe_att_spi_shifter.sv
// afe_att_spi_shifter: shifts one attenuator word MSB-first on SPI_CLK/SPI_SDI, then pulses SPI_LE.
// Define AFE_ATT_SPI_SKIP_UNCHANGED_EN to skip rewriting a word equal to the last latched one.
module afe_att_spi_shifter #(
   parameter int CLK_RATE = 99999001,
   parameter int SPI_RATE = 10000000,
   parameter int WIDTH    = 8
) (
   input logic                  sysClk,
   input logic                  sysReset,
   afe_att_spi_shifter_if.slave bus
);
   localparam int DIV_C = (CLK_RATE + 2*SPI_RATE - 1) / (2*SPI_RATE);
   localparam int DIV   = DIV_C < 1 ? 1 : DIV_C;
   localparam int CW    = DIV > 1 ? $clog2(DIV) : 1;
   localparam int IW    = WIDTH > 1 ? $clog2(WIDTH) : 1;
   typedef enum logic [2:0] {IDLE, BIT_LOW, BIT_HIGH, LE_SETUP, LE_HIGH} state_t;
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] sh;
   logic             last_tick;
   logic             skip;
   assign last_tick = cnt == CW'(DIV-1);
`ifdef AFE_ATT_SPI_SKIP_UNCHANGED_EN
   logic valid;
   assign skip = valid && bus.data == bus.lastValue;
`else
   assign skip = 1'b0;
`endif
   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         state         <= IDLE;
         cnt           <= '0;
         idx           <= '0;
         sh            <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.lastValue <= '0;
         bus.SPI_CLK   <= 1'b0;
         bus.SPI_SDI   <= 1'b0;
         bus.SPI_LE    <= 1'b0;
`ifdef AFE_ATT_SPI_SKIP_UNCHANGED_EN
         valid         <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         // half-period counter free-runs inside every timed state and wraps on its last tick
         cnt <= (state == IDLE || last_tick) ? '0 : cnt + CW'(1);
         case (state)
            IDLE: if (bus.start) begin
               if (skip) bus.done <= 1'b1;
               else begin
                  sh          <= bus.data;
                  idx         <= IW'(WIDTH-1);
                  bus.busy    <= 1'b1;
                  bus.SPI_CLK <= 1'b0;
                  bus.SPI_SDI <= bus.data[WIDTH-1];
                  state       <= BIT_LOW;
               end
            end
            BIT_LOW: if (last_tick) begin
               bus.SPI_CLK <= 1'b1;
               state       <= BIT_HIGH;
            end
            BIT_HIGH: if (last_tick) begin
               bus.SPI_CLK <= 1'b0;
               if (idx == '0) begin
                  bus.SPI_SDI <= 1'b0;
                  state       <= LE_SETUP;
               end else begin
                  idx         <= idx - IW'(1);
                  bus.SPI_SDI <= sh[idx - IW'(1)];
                  state       <= BIT_LOW;
               end
            end
            LE_SETUP: if (last_tick) begin
               bus.SPI_LE <= 1'b1;
               state      <= LE_HIGH;
            end
            LE_HIGH: if (last_tick) begin
               bus.SPI_LE    <= 1'b0;
               bus.busy      <= 1'b0;
               bus.done      <= 1'b1;
               bus.lastValue <= sh;
`ifdef AFE_ATT_SPI_SKIP_UNCHANGED_EN
               valid         <= 1'b1;
`endif
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
